// File: rtl/ts_merge_if.sv
// Timestamp merge bus: per-port input streams, the merged back-pressurable
// output stream, and the per-port drop status.
interface ts_merge_if #(
  parameter int DATA_WIDTH = 96,
  parameter int FP_WIDTH   = 8,
  parameter int NUM_PORTS  = 8,
  parameter int CNT_WIDTH  = 16
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]            i_ts_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] i_ts_data;
  logic [NUM_PORTS*FP_WIDTH-1:0]   i_ts_fp;
  logic                            o_ts_valid;
  logic                            i_ts_ready;
  logic [DATA_WIDTH-1:0]           o_ts_data;
  logic [FP_WIDTH-1:0]             o_ts_fp;
  logic [PW-1:0]                   o_ts_port;
  logic [NUM_PORTS-1:0]            o_ovf;
  logic [NUM_PORTS*CNT_WIDTH-1:0]  o_drop_cnt;

  modport master (
    output i_ts_valid, i_ts_data, i_ts_fp, i_ts_ready,
    input  o_ts_valid, o_ts_data, o_ts_fp, o_ts_port, o_ovf, o_drop_cnt
  );

  modport slave (
    input  i_ts_valid, i_ts_data, i_ts_fp, i_ts_ready,
    output o_ts_valid, o_ts_data, o_ts_fp, o_ts_port, o_ovf, o_drop_cnt
  );
endinterface

// File: rtl/ts_merge.sv
// Collects per-port timestamp returns into small FIFOs and drains them
// round-robin into one registered, back-pressurable output stage.
module ts_merge #(
  parameter int DATA_WIDTH = 96,
  parameter int FP_WIDTH   = 8,
  parameter int NUM_PORTS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  ts_merge_if.slave    bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + FP_WIDTH;

  logic [EW-1:0]        mem_q     [NUM_PORTS][FIFO_DEPTH];
  logic [EW-1:0]        mem_d     [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q  [NUM_PORTS];
  logic [AW-1:0]        wr_ptr_d  [NUM_PORTS];
  logic [AW-1:0]        rd_ptr_q  [NUM_PORTS];
  logic [AW-1:0]        rd_ptr_d  [NUM_PORTS];
  logic [AW:0]          count_q   [NUM_PORTS];
  logic [AW:0]          count_d   [NUM_PORTS];
  logic [CNT_WIDTH-1:0] drop_cnt_q[NUM_PORTS];
  logic [CNT_WIDTH-1:0] drop_cnt_d[NUM_PORTS];
  logic [NUM_PORTS-1:0] ovf_q, ovf_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [FP_WIDTH-1:0]  fp_q, fp_d;
  logic [PW-1:0]        port_q, port_d;

  logic                 load;
  logic                 found;
  logic [PW-1:0]        grant;
  logic [NUM_PORTS-1:0] pop;
  logic [EW-1:0]        head;

  // First non-empty port at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && (count_q[idx] != '0)) begin
        found = 1'b1;
        grant = PW'(idx);
      end
    end
  end

  assign load = ~valid_q | bus.i_ts_ready;
  assign head = mem_q[grant][rd_ptr_q[grant]];

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = '0;
    pop        = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      logic push;
      push   = 1'b0;
      pop[p] = load & found & (grant == PW'(p));
      if (bus.i_ts_valid[p]) begin
        // A full FIFO still accepts when its head leaves in the same cycle.
        if ((count_q[p] != (AW+1)'(FIFO_DEPTH)) || pop[p]) begin
          push = 1'b1;
          mem_d[p][wr_ptr_q[p]] = {bus.i_ts_data[p*DATA_WIDTH +: DATA_WIDTH],
                                   bus.i_ts_fp[p*FP_WIDTH +: FP_WIDTH]};
          wr_ptr_d[p] = wr_ptr_q[p] + 1'b1;
        end else begin
          ovf_d[p] = 1'b1;
          if (drop_cnt_q[p] != '1) drop_cnt_d[p] = drop_cnt_q[p] + 1'b1;
        end
      end
      if (pop[p]) rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
      case ({push, pop[p]})
        2'b10:   count_d[p] = count_q[p] + 1'b1;
        2'b01:   count_d[p] = count_q[p] - 1'b1;
        default: count_d[p] = count_q[p];
      endcase
    end
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    fp_d     = fp_q;
    port_d   = port_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      if (found) begin
        valid_d  = 1'b1;
        data_d   = head[EW-1:FP_WIDTH];
        fp_d     = head[FP_WIDTH-1:0];
        port_d   = grant;
        rr_ptr_d = (grant == PW'(NUM_PORTS-1)) ? '0 : grant + 1'b1;
      end else begin
        valid_d  = 1'b0;
      end
    end
  end

  // Storage has no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p]   <= '0;
        rd_ptr_q[p]   <= '0;
        count_q[p]    <= '0;
        drop_cnt_q[p] <= '0;
      end
      ovf_q    <= '0;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      fp_q     <= '0;
      port_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      rr_ptr_q   <= rr_ptr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      fp_q       <= fp_d;
      port_q     <= port_d;
    end
  end

  assign bus.o_ts_valid = valid_q;
  assign bus.o_ts_data  = data_q;
  assign bus.o_ts_fp    = fp_q;
  assign bus.o_ts_port  = port_q;
  assign bus.o_ovf      = ovf_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_drop
    assign bus.o_drop_cnt[p*CNT_WIDTH +: CNT_WIDTH] = drop_cnt_q[p];
  end
endmodule

// File: doc/ts_merge.md
Name: ts_merge

Overview:
- Merges eight per-port timestamp streams (valid, data, fingerprint) into one serialized, back-pressurable stream tagged with the source port index.
- It is the collecting counterpart of the per-port timestamp fan-out. It sits between the per-channel MAC timestamp returns and the single shared timestamp consumer (PTP/CSR path).
- Each port has a small FIFO. A round-robin arbiter drains the FIFOs into a registered output stage.

Parameters:
- DATA_WIDTH, 96: timestamp data width per port.
- FP_WIDTH, 8: fingerprint width per port.
- NUM_PORTS, 8: number of input ports; range 2..16.
- FIFO_DEPTH, 4: entries per port FIFO; power of 2, at least 2.
- CNT_WIDTH, 16: width of each per-port drop counter.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, asynchronous, active-high.
- i_ts_valid  in  NUM_PORTS  per-port timestamp valid; one-cycle qualifier, no backpressure to sources.
- i_ts_data  in  NUM_PORTS*DATA_WIDTH  packed data; port p occupies [p*DATA_WIDTH +: DATA_WIDTH].
- i_ts_fp  in  NUM_PORTS*FP_WIDTH  packed fingerprint; port p occupies [p*FP_WIDTH +: FP_WIDTH].
- o_ts_valid  out  1  merged output valid.
- i_ts_ready  in  1  consumer ready.
- o_ts_data  out  DATA_WIDTH  merged timestamp data.
- o_ts_fp  out  FP_WIDTH  merged fingerprint.
- o_ts_port  out  $clog2(NUM_PORTS)  source port index of the current output.
- o_ovf  out  NUM_PORTS  per-port one-cycle pulse; an input was dropped.
- o_drop_cnt  out  NUM_PORTS*CNT_WIDTH  per-port saturating drop counters, packed like i_ts_data.

Behaviour:
- Reset:
  - Clock is clk; reset is rst, asynchronous and active-high.
  - On rst: all FIFOs are emptied, rr_ptr=0, and o_ts_valid/o_ts_data/o_ts_fp/o_ts_port/o_ovf/o_drop_cnt all go to 0.
  - Reset asserted mid-operation discards all queued and in-flight entries, with no partial output.
- Push:
  - At the edge where i_ts_valid[p]=1, the port-p entry {data, fp} is written to FIFO p if count_p < FIFO_DEPTH, or if FIFO p is popped in the same cycle.
  - Otherwise the entry is dropped: o_ovf[p]=1 for the next cycle only, and drop_cnt[p] is incremented, saturating at all-ones.
- Output register load:
  - load = ~o_ts_valid | i_ts_ready.
  - When load=1 and any FIFO is non-empty, grant g = first non-empty port searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - On grant: pop FIFO g, load o_ts_data/o_ts_fp/o_ts_port=g, set o_ts_valid=1, and set rr_ptr <= (g+1) mod NUM_PORTS.
  - When load=1 and all FIFOs are empty: o_ts_valid <= 0, and the data/fp/port fields hold their last value.
- Handshake:
  - A transfer occurs when o_ts_valid & i_ts_ready.
  - While o_ts_valid=1 and i_ts_ready=0, all outputs hold stable and no pop occurs.
  - Full throughput is one entry per cycle with i_ts_ready held at 1.
- Latency: an input sampled at edge N, with empty FIFOs and an idle output, appears with o_ts_valid=1 after edge N+1, i.e. 2 cycles.
- Ordering: FIFO order is preserved within a port. Across ports the order is round-robin only; arrival order across ports is not preserved.
- Counters and pointers:
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - Occupancy uses log2(FIFO_DEPTH)+1 bits and distinguishes full from empty.
  - Drop counters never wrap and are cleared only by rst.
- rr_ptr advances only on a grant; it does not change while the output stalls.

Test Plan:
- Single entry: port 5 pulses valid with data=0x123, fp=0x2A, ready=1 -> o_ts_valid is high exactly 2 cycles later for one cycle, with port=5, data=0x123, fp=0x2A.
- Burst fairness: all 8 ports pulse simultaneously (fp=port index), ready=1 -> outputs on 8 consecutive cycles with port order 0,1,...,7 and no drops.
- Round robin: after port 3 is granted, ports 1 and 6 become pending -> port 6 is output before port 1.
- Backpressure: ready=0 for 10 cycles while port 2 pulses 3 times -> the first entry is held stable on the output; after ready=1, three entries drain in order on consecutive cycles; o_ovf stays 0.
- Overflow: ready=0, port 0 pulses 7 times (FIFO_DEPTH=4) -> 1 entry in the output register plus 4 in the FIFO are kept; 2 o_ovf[0] pulses; drop_cnt[0]=2; after ready=1 the first five values drain in order.
- Reset mid-operation: rst asserted with 3 entries queued and o_ts_valid=1 -> all outputs are immediately 0, and after release there is no output until new input arrives.
